// File: rtl/fft_ctrl_pkg.sv
// Shared configuration and FSM encoding for the FFT stage controller.
// Default parameter values mirror the config_FFT.svh build settings.
package fft_ctrl_pkg;

  localparam int FFT_N       = 16;
  localparam int FFT_SIZE    = 4;
  localparam int FFT_TIMEOUT = 1024;

  // cur_stage value reported while no stage is active.
  localparam int STAGE_IDLE  = FFT_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } fsm_state_t;

endpackage

// File: rtl/fft_stage_sequencer_watchdog.sv
// Per-stage watchdog: counts cycles while enabled and flags expiry at TIMEOUT-1.
// The count saturates at its limit so a stuck stage can never wrap it back to zero.
module stage_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            WW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] LIMIT = WW'(TIMEOUT - 1);

  logic [WW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == LIMIT);

endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences the log2(N) butterfly stages of one FFT frame, one stage at a time,
// with a per-stage watchdog and a one-deep queue for frame requests.
module fft_stage_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int N       = FFT_N,
  parameter int SIZE    = FFT_SIZE,
  parameter int TIMEOUT = FFT_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_req,
  input  logic [SIZE-1:0]           stage_done,
  output logic                      frame_ack,
  output logic [SIZE-1:0]           stage_start,
  output logic [$clog2(SIZE+1)-1:0] cur_stage,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      err_timeout,
  output logic [2:0]                dbg_state
);

  localparam int            CW         = $clog2(SIZE + 1);
  // Never address a stage beyond the stage_done/stage_start port width.
  localparam int            NUM_STAGES = ($clog2(N) < SIZE) ? $clog2(N) : SIZE;
  localparam logic [CW-1:0] LAST_STAGE = CW'(NUM_STAGES - 1);
  localparam logic [CW-1:0] IDLE_STAGE = CW'(SIZE);

  fsm_state_t      state, state_nxt;
  logic [CW-1:0]   k, k_nxt;
  logic            pending, pending_nxt;
  logic            ack_nxt, fdone_nxt, err_nxt, busy_nxt;
  logic [SIZE-1:0] start_nxt;
  logic [CW-1:0]   cur_nxt;
  logic            done_hit;
  logic            wd_expired;

  // Only the done bit of the stage being waited on is meaningful.
  assign done_hit  = |(stage_done & (SIZE'(1) << k));
  assign dbg_state = state;

  stage_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == ST_LAUNCH),
    .en      (state == ST_WAIT),
    .expired (wd_expired)
  );

  // Request handshake: frame_req is a one-cycle pulse with no back-pressure;
  // frame_ack pulses one cycle later when the request is started or queued,
  // and a request that finds the queue full (or the block in ERR) is dropped.
  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    pending_nxt = pending;
    ack_nxt     = 1'b0;
    fdone_nxt   = 1'b0;
    err_nxt     = err_timeout;
    busy_nxt    = busy;
    start_nxt   = '0;

    unique case (state)
      ST_IDLE: begin
        if (frame_req || pending) begin
          ack_nxt     = frame_req;
          pending_nxt = 1'b0;
          k_nxt       = '0;
          state_nxt   = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        start_nxt = SIZE'(1) << k;
        busy_nxt  = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the expiry cycle still wins over the watchdog.
        if (done_hit) begin
          if (k == LAST_STAGE) begin
            fdone_nxt = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = ST_DONE;
          end else begin
            k_nxt     = k + 1'b1;
            state_nxt = ST_LAUNCH;
          end
        end else if (wd_expired) begin
          err_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = ST_ERR;
        end
      end
      ST_DONE: begin
        // A queued request, or one arriving alongside frame_done, relaunches
        // stage 0 straight away instead of idling for a cycle.
        if (frame_req || pending) begin
          ack_nxt     = frame_req && !pending;
          pending_nxt = 1'b0;
          k_nxt       = '0;
          state_nxt   = ST_LAUNCH;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ERR: begin
        state_nxt = ST_ERR;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if ((state == ST_LAUNCH || state == ST_WAIT) && frame_req && !pending) begin
      pending_nxt = 1'b1;
      ack_nxt     = 1'b1;
    end

    cur_nxt = (state_nxt == ST_LAUNCH || state_nxt == ST_WAIT) ? k_nxt : IDLE_STAGE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      k           <= '0;
      pending     <= 1'b0;
      frame_ack   <= 1'b0;
      stage_start <= '0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      cur_stage   <= IDLE_STAGE;
    end else begin
      state       <= state_nxt;
      k           <= k_nxt;
      pending     <= pending_nxt;
      frame_ack   <= ack_nxt;
      stage_start <= start_nxt;
      frame_done  <= fdone_nxt;
      busy        <= busy_nxt;
      err_timeout <= err_nxt;
      cur_stage   <= cur_nxt;
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: each scenario is planned as a cycle timeline of
// stimulus and expected outputs, then replayed and compared cycle by cycle.
module tb_fft_stage_sequencer;

  localparam int SIZE = 4;
  localparam int TO   = 16;
  localparam int MAXC = 512;
  localparam int W    = 11;

  logic       clk;
  logic       rst;
  logic       frame_req;
  logic [3:0] stage_done;
  logic       frame_ack;
  logic [3:0] stage_start;
  logic [2:0] cur_stage;
  logic       busy;
  logic       frame_done;
  logic       err_timeout;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic         st_rst  [MAXC];
  logic         st_req  [MAXC];
  logic [3:0]   st_done [MAXC];
  logic         e_ack   [MAXC];
  logic [3:0]   e_start [MAXC];
  logic         e_fdone [MAXC];
  logic         e_busy  [MAXC];
  logic         e_err   [MAXC];
  logic [2:0]   e_cur   [MAXC];
  int           plan_s  [4];
  logic [W-1:0] exp_q[$];

  fft_stage_sequencer #(
    .N       (16),
    .SIZE    (SIZE),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_req   (frame_req),
    .stage_done  (stage_done),
    .frame_ack   (frame_ack),
    .stage_start (stage_start),
    .cur_stage   (cur_stage),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_timeout (err_timeout),
    .dbg_state   (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Fresh timeline: reset pulse at cycle 0, idle outputs afterwards.
  task automatic clear_plan();
    for (int c = 0; c < MAXC; c++) begin
      st_rst[c]  = (c == 0);
      st_req[c]  = 1'b0;
      st_done[c] = 4'b0;
      e_ack[c]   = 1'b0;
      e_start[c] = 4'b0;
      e_fdone[c] = 1'b0;
      e_busy[c]  = 1'b0;
      e_err[c]   = 1'b0;
      e_cur[c]   = 3'(SIZE);
    end
  endtask

  // One frame whose stage-0 launch is decided in cycle dec; stage k finishes
  // d_k cycles after its start pulse, d_k >= TO meaning it never finishes.
  task automatic plan_frame(input int dec, input int d0, input int d1, input int d2,
                            input int d3, input bit noise, output int fd);
    int d[4];
    int s;
    int s0;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    s  = dec + 2;
    s0 = s;
    fd = -1;
    for (int k = 0; k < SIZE; k++) begin
      plan_s[k]  = s;
      e_start[s] = 4'(1 << k);
      if (d[k] >= TO) begin
        for (int c = s - 1; c < s + TO; c++) e_cur[c] = 3'(k);
        for (int c = s0; c < s + TO; c++) e_busy[c] = 1'b1;
        for (int c = s + TO; c < MAXC; c++) e_err[c] = 1'b1;
        return;
      end
      for (int c = s - 1; c <= s + d[k]; c++) e_cur[c] = 3'(k);
      for (int c = s; c <= s + d[k]; c++) begin
        if (noise) st_done[c] = st_done[c] | (4'($urandom_range(0, 15)) & ~(4'(1 << k)));
      end
      st_done[s + d[k]] = st_done[s + d[k]] | 4'(1 << k);
      s = s + d[k] + 2;
    end
    fd = s - 1;
    e_fdone[fd] = 1'b1;
    for (int c = s0; c < fd; c++) e_busy[c] = 1'b1;
  endtask

  task automatic apply_reset(input int r);
    st_rst[r] = 1'b1;
    for (int c = r; c < MAXC; c++) begin
      st_req[c]  = 1'b0;
      st_done[c] = 4'b0;
    end
    for (int c = r + 1; c < MAXC; c++) begin
      e_ack[c]   = 1'b0;
      e_start[c] = 4'b0;
      e_fdone[c] = 1'b0;
      e_busy[c]  = 1'b0;
      e_err[c]   = 1'b0;
      e_cur[c]   = 3'(SIZE);
    end
  endtask

  task automatic run_scn(input string tag, input int len);
    logic [W-1:0] obs;
    logic [W-1:0] expv;
    exp_q.delete();
    for (int c = 1; c < len; c++)
      exp_q.push_back({e_ack[c], e_start[c], e_fdone[c], e_busy[c], e_err[c], e_cur[c]});
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      rst        = st_rst[c];
      frame_req  = st_req[c];
      stage_done = st_done[c];
      @(negedge clk);
      if (c >= 1) begin
        expv = exp_q.pop_front();
        obs  = {frame_ack, stage_start, frame_done, busy, err_timeout, cur_stage};
        checks++;
        assert (obs === expv) else begin
          errors++;
          $error("FAIL %s cyc=%0d observed ack,start,fdone,busy,err,cur=%b,%b,%b,%b,%b,%0d expected=%b,%b,%b,%b,%b,%0d",
                 tag, c, obs[10], obs[9:6], obs[5], obs[4], obs[3], obs[2:0],
                 expv[10], expv[9:6], expv[5], expv[4], expv[3], expv[2:0]);
        end
      end
    end
  endtask

  initial begin
    int fd;
    int fd2;
    int s1;
    int s2;
    int r;
    rst        = 1'b1;
    frame_req  = 1'b0;
    stage_done = 4'b0;

    // Reset values.
    clear_plan();
    run_scn("reset", 5);

    // Nominal run with ignored done bits in IDLE, WAIT, LAUNCH and DONE.
    clear_plan();
    st_done[1] = 4'b0001;
    st_req[2]  = 1'b1;
    e_ack[3]   = 1'b1;
    plan_frame(2, 10, 10, 10, 10, 1'b0, fd);
    st_done[plan_s[0] + 3] = st_done[plan_s[0] + 3] | 4'b0100;
    st_done[plan_s[2] - 1] = st_done[plan_s[2] - 1] | 4'b0100;
    st_done[fd]            = st_done[fd] | 4'b1000;
    st_done[fd + 1]        = st_done[fd + 1] | 4'b0001;
    run_scn("nominal", fd + 5);

    // Random stage latencies with random foreign done bits.
    for (int i = 0; i < 6; i++) begin
      clear_plan();
      r = $urandom_range(1, 4);
      st_req[r]    = 1'b1;
      e_ack[r + 1] = 1'b1;
      plan_frame(r, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
                 $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), 1'b1, fd);
      run_scn("random", fd + 4);
    end

    // Queued request during stage 2, third request dropped.
    clear_plan();
    st_req[2] = 1'b1;
    e_ack[3]  = 1'b1;
    plan_frame(2, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
               $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), 1'b0, fd);
    st_req[plan_s[2]]     = 1'b1;
    e_ack[plan_s[2] + 1]  = 1'b1;
    st_req[plan_s[3]]     = 1'b1;
    plan_frame(fd, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
               $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), 1'b0, fd2);
    run_scn("queued", fd2 + 6);

    // Request in the same cycle as frame_done.
    clear_plan();
    st_req[2] = 1'b1;
    e_ack[3]  = 1'b1;
    plan_frame(2, 4, 0, 7, 2, 1'b0, fd);
    st_req[fd]    = 1'b1;
    e_ack[fd + 1] = 1'b1;
    plan_frame(fd, 1, 3, 0, 5, 1'b0, fd2);
    run_scn("req_on_done", fd2 + 5);

    // Stage 1 never finishes: timeout, queued request stranded, later request ignored.
    clear_plan();
    st_req[2] = 1'b1;
    e_ack[3]  = 1'b1;
    plan_frame(2, $urandom_range(0, TO - 1), TO + 5, 3, 3, 1'b0, fd);
    s1 = plan_s[1];
    st_req[s1 + 1]      = 1'b1;
    e_ack[s1 + 2]       = 1'b1;
    st_req[s1 + TO + 4] = 1'b1;
    run_scn("timeout", s1 + TO + 10);

    // Done arriving on the watchdog expiry cycle.
    clear_plan();
    st_req[2] = 1'b1;
    e_ack[3]  = 1'b1;
    plan_frame(2, 3, TO - 1, 0, TO - 1, 1'b0, fd);
    run_scn("race", fd + 4);

    // Reset in stage 2 WAIT with a request pending.
    clear_plan();
    st_req[2] = 1'b1;
    e_ack[3]  = 1'b1;
    plan_frame(2, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), 12, 5, 1'b0, fd);
    s2 = plan_s[2];
    st_req[s2 + 1] = 1'b1;
    e_ack[s2 + 2]  = 1'b1;
    apply_reset(s2 + 3);
    run_scn("mid_reset", s2 + 14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
